// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: sequential PC generation, fixed 1-cycle imem reads,
// and a DEPTH-entry prefetch FIFO feeding decode with valid/ready.
module fetch_prefetch_queue #(
    parameter int                 ADDR_W   = 64,
    parameter int                 INSTR_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    input  logic               i_redirect,
    input  logic [ADDR_W-1:0]  i_redirect_pc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [INSTR_W-1:0] o_out_instr,
    output logic [ADDR_W-1:0]  o_out_pc,
    output logic [ADDR_W-1:0]  o_out_pc_plus4,
    output logic               o_misalign_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  r_fetch_pc;
    logic [ADDR_W-1:0]  r_issued_pc;
    logic               r_inflight;
    logic               r_kill;
    logic               r_misalign;
    logic [CNT_W-1:0]   r_count;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [INSTR_W-1:0] r_q_instr [DEPTH];
    logic [ADDR_W-1:0]  r_q_pc    [DEPTH];

    logic [CNT_W-1:0]   w_occupancy;
    logic               w_issue;
    logic               w_resp;
    logic               w_out_valid;
    logic               w_deq;

    // Slots already promised: buffered words plus the read still in flight.
    always_comb begin
        w_occupancy = r_count + {{PTR_W{1'b0}}, r_inflight};
        w_issue     = !i_rst && !i_redirect && (w_occupancy < CNT_W'(DEPTH));
        w_resp      = r_inflight && !r_kill && !i_redirect;
        w_out_valid = !i_rst && (r_count != '0);
        w_deq       = w_out_valid && i_out_ready;
    end

    assign o_imem_req     = w_issue;
    assign o_imem_addr    = r_fetch_pc;
    assign o_out_valid    = w_out_valid;
    assign o_out_instr    = r_q_instr[r_rd_ptr];
    assign o_out_pc       = r_q_pc[r_rd_ptr];
    assign o_out_pc_plus4 = r_q_pc[r_rd_ptr] + ADDR_W'(4);
    assign o_misalign_err = r_misalign && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_pc  <= RESET_PC;
            r_issued_pc <= RESET_PC;
            r_inflight  <= 1'b0;
            r_kill      <= 1'b0;
            r_misalign  <= 1'b0;
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else if (i_redirect) begin
            r_fetch_pc  <= {i_redirect_pc[ADDR_W-1:2], 2'b00};
            r_inflight  <= 1'b0;
            r_kill      <= r_inflight;
            r_misalign  <= |i_redirect_pc[1:0];
            r_count     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
        end else begin
            r_inflight <= w_issue;
            r_kill     <= 1'b0;
            r_misalign <= 1'b0;
            if (w_issue) begin
                r_fetch_pc  <= r_fetch_pc + ADDR_W'(4);
                r_issued_pc <= r_fetch_pc;
            end
            if (w_resp) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_resp, w_deq})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset; entries are only visible once count covers them.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_resp) begin
            r_q_instr[r_wr_ptr] <= i_imem_rdata;
            r_q_pc[r_wr_ptr]    <= r_issued_pc;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a 1-cycle-latency instruction memory model.
module tb_fetch_prefetch_queue;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;

    logic               clk;
    logic               rst;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pc_plus4;
    logic               misalign_err;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_prefetch_queue #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .RESET_PC('0)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .o_imem_req     (imem_req),
        .o_imem_addr    (imem_addr),
        .i_imem_rdata   (imem_rdata),
        .i_redirect     (redirect),
        .i_redirect_pc  (redirect_pc),
        .o_out_valid    (out_valid),
        .i_out_ready    (out_ready),
        .o_out_instr    (out_instr),
        .o_out_pc       (out_pc),
        .o_out_pc_plus4 (out_pc_plus4),
        .o_misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'h5A5A_0000;
    endfunction

    // Memory returns the word for whatever address was presented last cycle.
    always @(posedge clk) imem_rdata <= mem_word(imem_addr);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0 after reset (inputs applied, outputs settled).
    task automatic do_reset(input logic ready);
        next_cycle();
        rst = 1'b1; redirect = 1'b0; out_ready = ready;
        #1;
        next_cycle();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        next_cycle();
        rst = 1'b0; redirect = 1'b1; redirect_pc = 64'h3; out_ready = 1'b1;
        #1;
        next_cycle();
        redirect = 1'b0; rst = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        n_checks++;
        if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_misalign got=%b exp=0", misalign_err); end
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_fail++; $display("FAIL reset_first_req got=%b/%h exp=1/0", imem_req, imem_addr);
        end
        n_checks++;
        if (out_valid !== 1'b0 || misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle got=%b/%b exp=0/0", out_valid, misalign_err);
        end
    endtask

    task automatic test_sequential();
        do_reset(1'b1);
        for (int k = 0; k < 10; k++) begin
            if (k != 0) next_cycle();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 64'(4 * k)) begin
                n_fail++; $display("FAIL seq_addr k=%0d got=%b/%h exp=1/%h", k, imem_req, imem_addr, 64'(4 * k));
            end
            n_checks++;
            if (k < 2) begin
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL seq_early_valid k=%0d got=%b exp=0", k, out_valid); end
            end else begin
                if (out_valid !== 1'b1 || out_pc !== 64'(4 * (k - 2)) || out_pc_plus4 !== 64'(4 * (k - 1))
                    || out_instr !== mem_word(64'(4 * (k - 2)))) begin
                    n_fail++;
                    $display("FAIL seq_out k=%0d got v=%b pc=%h pc4=%h ins=%h exp pc=%h", k, out_valid, out_pc,
                             out_pc_plus4, out_instr, 64'(4 * (k - 2)));
                end
            end
        end
    endtask

    task automatic test_stall();
        int req_cnt;
        req_cnt = 0;
        do_reset(1'b0);
        for (int k = 0; k < 8; k++) begin
            if (k != 0) next_cycle();
            if (imem_req === 1'b1) req_cnt++;
            if (k >= 2) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== mem_word(64'h0)) begin
                    n_fail++; $display("FAIL stall_hold k=%0d got v=%b pc=%h ins=%h exp 1/0", k, out_valid, out_pc, out_instr);
                end
            end
        end
        n_checks++;
        if (req_cnt !== 4) begin n_fail++; $display("FAIL stall_req_count got=%0d exp=4", req_cnt); end
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req_off got=%b exp=0", imem_req); end
        next_cycle();
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 6; j++) begin
            if (j != 0) next_cycle();
            n_checks++;
            if (out_valid !== 1'b1 || out_pc !== 64'(4 * j)) begin
                n_fail++; $display("FAIL stall_drain j=%0d got v=%b pc=%h exp 1/%h", j, out_valid, out_pc, 64'(4 * j));
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(1'b0);
        repeat (4) next_cycle();
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL redir_pre got req=%b v=%b exp 0/1", imem_req, out_valid);
        end
        redirect = 1'b1; redirect_pc = 64'h100; out_ready = 1'b1;
        #1;
        next_cycle();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h100 || misalign_err !== 1'b0) begin
            n_fail++; $display("FAIL redir_next got v=%b req=%b addr=%h mis=%b exp 0/1/100/0", out_valid, imem_req,
                               imem_addr, misalign_err);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL redir_gap got=%b exp=0", out_valid); end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_instr !== mem_word(64'h100)) begin
            n_fail++; $display("FAIL redir_target got v=%b pc=%h ins=%h exp 1/100", out_valid, out_pc, out_instr);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h104) begin
            n_fail++; $display("FAIL redir_follow got v=%b pc=%h exp 1/104", out_valid, out_pc);
        end
    endtask

    task automatic test_misalign();
        next_cycle();
        redirect = 1'b1; redirect_pc = 64'h103;
        #1;
        next_cycle();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (misalign_err !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 64'h100) begin
            n_fail++; $display("FAIL misalign_pulse got mis=%b req=%b addr=%h exp 1/1/100", misalign_err, imem_req, imem_addr);
        end
        next_cycle();
        n_checks++;
        if (misalign_err !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL misalign_clear got mis=%b v=%b exp 0/0", misalign_err, out_valid);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h100 || out_pc_plus4 !== 64'h104) begin
            n_fail++; $display("FAIL misalign_target got v=%b pc=%h pc4=%h exp 1/100/104", out_valid, out_pc, out_pc_plus4);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        redirect = 1'b1; redirect_pc = 64'h200;
        #1;
        next_cycle();
        redirect_pc = 64'h300;
        #1;
        n_checks++;
        if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_no_issue got=%b exp=0", imem_req); end
        next_cycle();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 64'h300 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_addr got addr=%h v=%b exp 300/0", imem_addr, out_valid);
        end
        next_cycle();
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h300) begin
            n_fail++; $display("FAIL b2b_target got v=%b pc=%h exp 1/300", out_valid, out_pc);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h304) begin
            n_fail++; $display("FAIL b2b_follow got v=%b pc=%h exp 1/304", out_valid, out_pc);
        end
    endtask

    task automatic test_wrap();
        next_cycle();
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        #1;
        next_cycle();
        redirect = 1'b0;
        #1;
        n_checks++;
        if (imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_top_addr got=%h exp=fffffffffffffffc", imem_addr);
        end
        next_cycle();
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_fail++; $display("FAIL wrap_addr got req=%b addr=%h exp 1/0", imem_req, imem_addr);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'hFFFF_FFFF_FFFF_FFFC || out_pc_plus4 !== 64'h0) begin
            n_fail++; $display("FAIL wrap_pc4 got v=%b pc=%h pc4=%h exp 1/fffffffffffffffc/0", out_valid, out_pc, out_pc_plus4);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_pc_plus4 !== 64'h4 || out_instr !== mem_word(64'h0)) begin
            n_fail++; $display("FAIL wrap_next got v=%b pc=%h pc4=%h ins=%h exp 1/0/4", out_valid, out_pc, out_pc_plus4, out_instr);
        end
    endtask

    task automatic test_rst_mid();
        do_reset(1'b0);
        repeat (4) next_cycle();
        rst = 1'b1; out_ready = 1'b1; redirect = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_during got req=%b v=%b exp 0/0", imem_req, out_valid);
        end
        next_cycle();
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 64'h0) begin
            n_fail++; $display("FAIL rstmid_after got v=%b req=%b addr=%h exp 0/1/0", out_valid, imem_req, imem_addr);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_gap got=%b exp=0", out_valid); end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h0 || out_instr !== mem_word(64'h0)) begin
            n_fail++; $display("FAIL rstmid_first got v=%b pc=%h ins=%h exp 1/0", out_valid, out_pc, out_instr);
        end
        next_cycle();
        n_checks++;
        if (out_valid !== 1'b1 || out_pc !== 64'h4) begin
            n_fail++; $display("FAIL rstmid_second got v=%b pc=%h exp 1/4", out_valid, out_pc);
        end
    endtask

    initial begin
        rst = 1'b1; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
